qspi_psram_ctrl: RTL and testbench
==================================

// Module: qspi_psram_ctrl
// PURPOSE
//  QSPI master in front of the QSPI PSRAM (qspi_psram_model in simulation). Turns single-word CPU bus
//  read/write requests into EB (fast read quad) / 38 (quad write) transactions on sck/ce_n/sio.
//  Issues the 66/99 reset-enable/reset pair after reset and reports readiness.
//  Sits between the CPU memory bus and the PSRAM pads (sio tristate is resolved outside).
// PARAMETERS
//  SCK_HALF  2   clk cycles per sck half-period (>=2); sck = clk/(2*SCK_HALF)
//  RD_WAIT   6   dummy sck cycles between last address nibble and first read nibble
//  CE_GAP    2   min sck periods ce_n held high between transactions
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   asynchronous active-low reset
//  req        in   1   request strobe, sampled only when busy=0 and init_done=1
//  we         in   1   1=write, 0=read (valid with req)
//  adr        in   24  byte address (valid with req); word access, adr[1:0] ignored (forced 0)
//  wdata      in   32  write data (valid with req)
//  rdata      out  32  read data, valid in ack cycle, held until next read completes
//  ack        out  1   one-clk pulse when transaction finished (ce_n already high)
//  busy       out  1   high from req accept until ack inclusive, and during init
//  init_done  out  1   high after 66/99 sequence completes, stays high until reset
//  sck        out  1   QSPI clock, idles low (mode 0)
//  ce_n       out  1   chip enable, active low
//  sio_o      out  4   data to pads
//  sio_oe     out  1   sio_o drive enable (0 only during RD_WAIT tail and read data)
//  sio_i      in   4   data from pads
// BEHAVIOUR
//  - Reset values: sck=0, ce_n=1, sio_o=0, sio_oe=1, ack=0, busy=1, init_done=0, rdata=0.
//  - Clock is one clk, reset is asynchronous and active-low; reset mid-transaction aborts immediately
//    (ce_n=1, sck=0) and restarts init sequence. Request not acked; host must reissue.
//  - Phase counter divides clk by SCK_HALF. Master changes sio_o/sio_oe only in the clk where sck
//    goes 1->0 (or before first rise). Read nibbles sampled from sio_i in the clk where sck goes 1->0.
//  - Command phase: 8 sck cycles, bit 7 first on sio_o[0], sio_o[3:1]=0.
//  - Address phase: 6 sck cycles, one nibble each, adr[23:20] first.
//  - Write data: 8 nibbles, byte order wdata[7:0],[15:8],[23:16],[31:24]; high nibble first in
//    each byte (matches PSRAM sequential byte addressing).
//  - Read: RD_WAIT dummy sck cycles (sio_oe drops to 0 at start of dummy phase), then 8 nibbles,
//    packed into rdata in the same order as write data.
//  - FSM: INIT_RSTEN(cmd 66) -> GAP -> INIT_RST(cmd 99) -> GAP -> IDLE(init_done=1)
//         IDLE --req--> CMD -> ADR -> {WDATA | RWAIT -> RDATA} -> END -> GAP -> IDLE
//    END: sck returns low, ce_n=1, ack pulses, rdata updated. GAP: ce_n high CE_GAP sck periods.
//  - ce_n falls SCK_HALF clks before first sck rise; rises SCK_HALF clks after last sck fall.
//  - req while busy=1 is ignored (not queued). req with init_done=0 ignored.
//  - Address beyond PSRAM size wraps in the device; controller passes the 24 bits unchanged.
//  - Per transaction: 8+6+8 sck (write), 8+6+RD_WAIT+8 sck (read), plus CE overhead.
// STRUCTURE
//  - Shared package/header qspi_defs: command opcodes (EB, 38, 66, 99), FSM state encodings,
//    phase lengths (CMD_LEN=8, ADR_LEN=6, DAT_LEN=8). Same opcode names as the PSRAM model.
//  - One sub-module: qspi_sck_gen (divider; outputs sck, rise/fall strobes, enable input).
//  - Main body: FSM, nibble counter (4 bit), 32-bit shift register shared for tx/rx.
// TESTING (bench: qspi_psram_ctrl + qspi_psram_model, sio resolved via sio_oe)
//  - Reset release -> ce_n frames carrying 0x66 then 0x99 on sio[0]; init_done=1 afterwards, busy=0.
//  - Write adr=0x000100 wdata=0x12345678 -> one ack; model memory bytes 0x100..0x103 = 78,56,34,12.
//  - Read adr=0x000100 after the write -> ack with rdata=0x12345678; sio_oe=0 during wait+data.
//  - Two back-to-back writes (0x0, 0xA5A5A5A5 / 0x4, 0x5A5A5A5A), reads back -> both correct;
//    ce_n high >= CE_GAP sck periods between frames.
//  - req held while busy -> exactly one transaction and one ack; req before init_done -> no ce_n activity.
//  - rst_n asserted during read data phase -> ce_n=1, sck=0 immediately, no ack, init sequence reruns.

Source files
------------

// File: rtl/qspi_psram_ctrl_pkg.sv
// Shared definitions for the QSPI PSRAM controller: opcodes, FSM state codes,
// phase lengths and the byte-lane helper used for tx/rx data ordering.
package qspi_psram_ctrl_pkg;

    // PSRAM opcodes (same names as the PSRAM model)
    localparam logic [7:0] CMD_QREAD  = 8'hEB;
    localparam logic [7:0] CMD_QWRITE = 8'h38;
    localparam logic [7:0] CMD_RSTEN  = 8'h66;
    localparam logic [7:0] CMD_RST    = 8'h99;

    // Phase lengths in sck cycles
    localparam int unsigned CMD_LEN = 8;
    localparam int unsigned ADR_LEN = 6;
    localparam int unsigned DAT_LEN = 8;

    // FSM state encodings (kept as constants for compatibility with existing code)
    localparam logic [3:0] ST_RSTEN = 4'd0;
    localparam logic [3:0] ST_RST   = 4'd1;
    localparam logic [3:0] ST_IDLE  = 4'd2;
    localparam logic [3:0] ST_CMD   = 4'd3;
    localparam logic [3:0] ST_ADR   = 4'd4;
    localparam logic [3:0] ST_WDATA = 4'd5;
    localparam logic [3:0] ST_RWAIT = 4'd6;
    localparam logic [3:0] ST_RDATA = 4'd7;
    localparam logic [3:0] ST_END   = 4'd8;
    localparam logic [3:0] ST_GAP   = 4'd9;

    // Kind of frame currently on the wire
    typedef enum logic [1:0] {
        OP_RSTEN,
        OP_RST,
        OP_WRITE,
        OP_READ
    } op_e;

    // PSRAM streams bytes in ascending address order, high nibble first;
    // swapping the byte lanes turns that into a plain MSB-first shift.
    function automatic logic [31:0] byte_swap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/qspi_psram_ctrl_sck_gen.sv
// QSPI clock divider: sck toggles every SCK_HALF clks while enabled, idles low.
// rise/fall strobe the clk cycle whose closing edge moves sck 0->1 / 1->0.
module qspi_psram_ctrl_sck_gen #(
    parameter int unsigned SCK_HALF = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sck,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;

    logic [CW-1:0] cnt;
    logic          last;

    assign last = en && (cnt == CW'(SCK_HALF - 1));
    assign rise = last && !sck;
    assign fall = last && sck;

    // Half-period counter and sck toggle; disabling returns sck low immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (last) begin
            cnt <= '0;
            sck <= ~sck;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/qspi_psram_ctrl.sv
// QSPI PSRAM master: runs the 66/99 reset pair after reset, then turns single
// word bus requests into EB (quad read) / 38 (quad write) frames.
module qspi_psram_ctrl
    import qspi_psram_ctrl_pkg::*;
#(
    parameter int unsigned SCK_HALF = 2,
    parameter int unsigned RD_WAIT  = 6,
    parameter int unsigned CE_GAP   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [23:0] adr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic        init_done,
    output logic        sck,
    output logic        ce_n,
    output logic [3:0]  sio_o,
    output logic        sio_oe,
    input  logic [3:0]  sio_i
);

    localparam int unsigned GAP_CLKS = CE_GAP * 2 * SCK_HALF;
    localparam int unsigned WCW      = $clog2(GAP_CLKS + 1);

    logic [3:0]     state;
    op_e            op;
    logic [3:0]     nib_cnt;
    logic [31:0]    shreg;
    logic [31:0]    wdata_r;
    logic [WCW-1:0] wcnt;
    logic           sck_en;
    logic           sck_rise;
    logic           sck_fall;
    logic           launch;
    logic [7:0]     launch_cmd;
    op_e            launch_op;

    assign sck_en = state inside {ST_CMD, ST_ADR, ST_WDATA, ST_RWAIT, ST_RDATA};
    assign busy   = (state != ST_IDLE);

    qspi_psram_ctrl_sck_gen #(
        .SCK_HALF(SCK_HALF)
    ) u_sck_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (sck_en),
        .sck  (sck),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    // Select which frame (if any) starts this cycle
    always_comb begin
        launch     = 1'b0;
        launch_cmd = CMD_RSTEN;
        launch_op  = OP_RSTEN;
        case (state)
            ST_RSTEN: launch = 1'b1;
            ST_RST: begin
                launch     = 1'b1;
                launch_cmd = CMD_RST;
                launch_op  = OP_RST;
            end
            ST_IDLE: begin
                if (req) begin
                    launch     = 1'b1;
                    launch_cmd = we ? CMD_QWRITE : CMD_QREAD;
                    launch_op  = we ? OP_WRITE : OP_READ;
                end
            end
            default: ;
        endcase
    end

    // Frame sequencer: ce_n framing, shared tx/rx shift register, phase counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RSTEN;
            op        <= OP_RSTEN;
            nib_cnt   <= '0;
            shreg     <= '0;
            wdata_r   <= '0;
            wcnt      <= '0;
            ce_n      <= 1'b1;
            sio_o     <= '0;
            sio_oe    <= 1'b1;
            ack       <= 1'b0;
            rdata     <= '0;
            init_done <= 1'b0;
        end else begin
            ack <= 1'b0;
            // nib_cnt counts sck rises in the current phase; phase ends on the following fall
            if (sck_rise) begin
                nib_cnt <= nib_cnt + 4'd1;
            end
            if (launch) begin
                // First command bit goes out now, half an sck period before the first rise
                op      <= launch_op;
                ce_n    <= 1'b0;
                sio_o   <= {3'b000, launch_cmd[7]};
                shreg   <= {launch_cmd[6:0], adr & 24'hFF_FFFC, 1'b0};
                wdata_r <= byte_swap(wdata);
                nib_cnt <= '0;
                state   <= ST_CMD;
            end else begin
                case (state)
                    ST_CMD: begin
                        if (sck_fall) begin
                            if (nib_cnt == 4'(CMD_LEN)) begin
                                nib_cnt <= '0;
                                if (op inside {OP_RSTEN, OP_RST}) begin
                                    sio_o <= '0;
                                    wcnt  <= '0;
                                    state <= ST_END;
                                end else begin
                                    sio_o <= shreg[31:28];
                                    shreg <= {shreg[27:0], 4'h0};
                                    state <= ST_ADR;
                                end
                            end else begin
                                sio_o <= {3'b000, shreg[31]};
                                shreg <= {shreg[30:0], 1'b0};
                            end
                        end
                    end
                    ST_ADR: begin
                        if (sck_fall) begin
                            if (nib_cnt == 4'(ADR_LEN)) begin
                                nib_cnt <= '0;
                                if (op == OP_WRITE) begin
                                    sio_o <= wdata_r[31:28];
                                    shreg <= {wdata_r[27:0], 4'h0};
                                    state <= ST_WDATA;
                                end else begin
                                    sio_oe <= 1'b0;
                                    state  <= (RD_WAIT == 0) ? ST_RDATA : ST_RWAIT;
                                end
                            end else begin
                                sio_o <= shreg[31:28];
                                shreg <= {shreg[27:0], 4'h0};
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (sck_fall) begin
                            if (nib_cnt == 4'(DAT_LEN)) begin
                                sio_o <= '0;
                                wcnt  <= '0;
                                state <= ST_END;
                            end else begin
                                sio_o <= shreg[31:28];
                                shreg <= {shreg[27:0], 4'h0};
                            end
                        end
                    end
                    ST_RWAIT: begin
                        if (sck_fall && nib_cnt == 4'(RD_WAIT)) begin
                            nib_cnt <= '0;
                            state   <= ST_RDATA;
                        end
                    end
                    ST_RDATA: begin
                        if (sck_fall) begin
                            shreg <= {shreg[27:0], sio_i};
                            if (nib_cnt == 4'(DAT_LEN)) begin
                                sio_oe <= 1'b1;
                                wcnt   <= '0;
                                state  <= ST_END;
                            end
                        end
                    end
                    ST_END: begin
                        if (wcnt == WCW'(SCK_HALF - 1)) begin
                            ce_n  <= 1'b1;
                            wcnt  <= '0;
                            state <= ST_GAP;
                            if (op inside {OP_WRITE, OP_READ}) begin
                                ack <= 1'b1;
                            end
                            if (op == OP_READ) begin
                                rdata <= byte_swap(shreg);
                            end
                        end else begin
                            wcnt <= wcnt + WCW'(1);
                        end
                    end
                    ST_GAP: begin
                        if (wcnt == WCW'(GAP_CLKS - 1)) begin
                            wcnt <= '0;
                            if (op == OP_RSTEN) begin
                                state <= ST_RST;
                            end else begin
                                state <= ST_IDLE;
                                if (op == OP_RST) begin
                                    init_done <= 1'b1;
                                end
                            end
                        end else begin
                            wcnt <= wcnt + WCW'(1);
                        end
                    end
                    ST_RSTEN, ST_RST, ST_IDLE: ;
                    default: state <= ST_RSTEN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qspi_psram_ctrl.sv
// Bench for qspi_psram_ctrl with a behavioural QSPI PSRAM device model and a
// word-level reference memory.
module tb_qspi_psram_ctrl;

    localparam int unsigned SCK_HALF  = 2;
    localparam int unsigned RD_WAIT   = 6;
    localparam int unsigned CE_GAP    = 2;
    localparam int unsigned MEM_BYTES = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [23:0] adr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ack, busy, init_done, sck, ce_n, sio_oe;
    logic [3:0]  sio_o, sio_i;
    logic [3:0]  mdl_drv = '0;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    assign sio_i = sio_oe ? sio_o : mdl_drv;

    qspi_psram_ctrl #(
        .SCK_HALF(SCK_HALF),
        .RD_WAIT (RD_WAIT),
        .CE_GAP  (CE_GAP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .we       (we),
        .adr      (adr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ack      (ack),
        .busy     (busy),
        .init_done(init_done),
        .sck      (sck),
        .ce_n     (ce_n),
        .sio_o    (sio_o),
        .sio_oe   (sio_oe),
        .sio_i    (sio_i)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- PSRAM device model ----------------
    logic [7:0]  mem [MEM_BYTES];
    logic [31:0] ref_word [MEM_BYTES/4];
    logic [7:0]  m_cmd = '0;
    logic [23:0] m_adr = '0;
    logic [3:0]  m_hi = '0;
    logic [7:0]  frames [$];
    int unsigned rises = 0, ce_fall_cyc = 0, ce_rise_cyc = 0, last_fall_cyc = 0;
    int unsigned min_gap = 32'hFFFF_FFFF;
    int unsigned oe_bad = 0, oe_low = 0, lead_bad = 0, tail_bad = 0, ack_cnt = 0;

    always @(negedge ce_n) begin
        if (ce_rise_cyc != 0 && (cyc - ce_rise_cyc) < min_gap) min_gap = cyc - ce_rise_cyc;
        ce_fall_cyc = cyc;
        rises = 0;
        m_cmd = '0;
        m_adr = '0;
    end

    always @(posedge ce_n) begin
        frames.push_back(m_cmd);
        ce_rise_cyc = cyc;
        if (rst_n && (cyc - last_fall_cyc) != SCK_HALF) tail_bad++;
    end

    always @(posedge sck) begin
        if (!ce_n) begin
            if (rises == 0 && (cyc - ce_fall_cyc) != SCK_HALF) lead_bad++;
            if (m_cmd == 8'hEB && rises >= 14) begin
                if (sio_oe !== 1'b0) oe_bad++;
                else oe_low++;
            end else if (sio_oe !== 1'b1) begin
                oe_bad++;
            end
            if (rises < 8) begin
                m_cmd = {m_cmd[6:0], sio_i[0]};
            end else if (rises < 14) begin
                m_adr = {m_adr[19:0], sio_i};
            end else if (m_cmd == 8'h38) begin
                if (rises % 2 == 0) m_hi = sio_i;
                else mem[(m_adr + (rises - 15) / 2) % MEM_BYTES] = {m_hi, sio_i};
            end
            rises++;
        end
    end

    always @(negedge sck) begin
        int unsigned k;
        logic [7:0]  b;
        last_fall_cyc = cyc;
        if (!ce_n && m_cmd == 8'hEB && rises >= 14 + RD_WAIT) begin
            k = rises - (14 + RD_WAIT);
            b = mem[(m_adr + k / 2) % MEM_BYTES];
            mdl_drv = (k % 2 == 0) ? b[7:4] : b[3:0];
        end
    end

    always @(negedge clk) if (ack) ack_cnt++;

    // ---------------- helpers ----------------
    function automatic int unsigned widx(input logic [23:0] a);
        return (int'(a) % MEM_BYTES) / 4;
    endfunction

    task automatic do_req(input logic w, input logic [23:0] a, input logic [31:0] d,
                          output bit acked, output logic [31:0] rd);
        int unsigned n;
        acked = 1'b0;
        rd    = '0;
        n     = 0;
        @(negedge clk);
        while ((busy || !init_done) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        req = 1'b1; we = w; adr = a; wdata = d;
        @(negedge clk);
        req = 1'b0;
        for (int unsigned i = 0; i < 400; i++) begin
            if (ack) begin
                acked = 1'b1;
                rd    = rdata;
                break;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        logic [9:0]  got;
        logic [15:0] fr;
        int unsigned n;
        rst_n = 1'b0;
        req   = 1'b0;
        repeat (3) @(negedge clk);
        got = {sck, ce_n, sio_o, sio_oe, ack, busy, init_done};
        n_cmp++;
        if (got !== 10'b0_1_0000_1_0_1_0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want %b", got, 10'b0_1_0000_1_0_1_0);
        end
        n_cmp++;
        if (rdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_rdata: got %h want 00000000", rdata);
        end
        frames.delete();
        ack_cnt = 0;
        // request held through init must be ignored
        req = 1'b1; we = 1'b1; adr = 24'h000200; wdata = 32'hDEADBEEF;
        rst_n = 1'b1;
        n = 0;
        while (!init_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        req = 1'b0;
        n_cmp++;
        if (init_done !== 1'b1) begin
            n_err++;
            $display("FAIL init_done_timeout: got %b want 1", init_done);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL init_busy: got %b want 0", busy);
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (frames.size() != 2) begin
            n_err++;
            $display("FAIL init_frame_count: got %0d want 2", frames.size());
        end
        fr = (frames.size() >= 2) ? {frames[0], frames[1]} : 16'h0000;
        n_cmp++;
        if (fr !== 16'h6699) begin
            n_err++;
            $display("FAIL init_opcodes: got %h want 6699", fr);
        end
        n_cmp++;
        if (ack_cnt != 0) begin
            n_err++;
            $display("FAIL req_before_init_ack: got %0d want 0", ack_cnt);
        end
    endtask

    task automatic test_write;
        bit          ok;
        logic [31:0] rd, bytes;
        do_req(1'b1, 24'h000100, 32'h12345678, ok, rd);
        ref_word[widx(24'h000100)] = 32'h12345678;
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL write_ack: got 0 want 1");
        end
        bytes = {mem[12'h100], mem[12'h101], mem[12'h102], mem[12'h103]};
        n_cmp++;
        if (bytes !== 32'h78563412) begin
            n_err++;
            $display("FAIL write_bytes: got %h want 78563412", bytes);
        end
    endtask

    task automatic test_read;
        bit          ok;
        logic [31:0] rd;
        int unsigned low0;
        low0 = oe_low;
        do_req(1'b0, 24'h000100, 32'h0, ok, rd);
        n_cmp++;
        if (!ok || rd !== 32'h12345678) begin
            n_err++;
            $display("FAIL read_data: got ack=%b rdata=%h want ack=1 rdata=12345678", ok, rd);
        end
        n_cmp++;
        if (oe_low - low0 != RD_WAIT + 8) begin
            n_err++;
            $display("FAIL read_oe_low_cycles: got %0d want %0d", oe_low - low0, RD_WAIT + 8);
        end
    endtask

    task automatic test_back_to_back;
        bit          ok;
        logic [31:0] rd;
        min_gap = 32'hFFFF_FFFF;
        do_req(1'b1, 24'h000000, 32'hA5A5A5A5, ok, rd);
        ref_word[0] = 32'hA5A5A5A5;
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL b2b_write0_ack: got 0 want 1"); end
        do_req(1'b1, 24'h000004, 32'h5A5A5A5A, ok, rd);
        ref_word[1] = 32'h5A5A5A5A;
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL b2b_write4_ack: got 0 want 1"); end
        do_req(1'b0, 24'h000000, 32'h0, ok, rd);
        n_cmp++;
        if (!ok || rd !== 32'hA5A5A5A5) begin
            n_err++;
            $display("FAIL b2b_read0: got ack=%b rdata=%h want ack=1 rdata=a5a5a5a5", ok, rd);
        end
        do_req(1'b0, 24'h000004, 32'h0, ok, rd);
        n_cmp++;
        if (!ok || rd !== 32'h5A5A5A5A) begin
            n_err++;
            $display("FAIL b2b_read4: got ack=%b rdata=%h want ack=1 rdata=5a5a5a5a", ok, rd);
        end
        n_cmp++;
        if (min_gap < CE_GAP * 2 * SCK_HALF) begin
            n_err++;
            $display("FAIL b2b_ce_gap: got %0d clks want >= %0d", min_gap, CE_GAP * 2 * SCK_HALF);
        end
    endtask

    task automatic test_busy_hold;
        int unsigned a0, f0, n;
        logic [31:0] d;
        d = $urandom;
        n = 0;
        @(negedge clk);
        while (busy && n < 1000) begin @(negedge clk); n++; end
        a0 = ack_cnt;
        f0 = frames.size();
        req = 1'b1; we = 1'b1; adr = 24'h000300; wdata = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 400);
        req = 1'b0;
        ref_word[widx(24'h000300)] = d;
        repeat (30) @(negedge clk);
        n_cmp++;
        if (ack_cnt - a0 != 1) begin
            n_err++;
            $display("FAIL busy_hold_acks: got %0d want 1", ack_cnt - a0);
        end
        n_cmp++;
        if (frames.size() - f0 != 1) begin
            n_err++;
            $display("FAIL busy_hold_frames: got %0d want 1", frames.size() - f0);
        end
    endtask

    task automatic test_random;
        bit          ok, w;
        logic [23:0] a;
        logic [31:0] d, rd;
        for (int unsigned i = 0; i < 40; i++) begin
            w = 1'($urandom_range(0, 1));
            a = (24'($urandom) & 24'hFF_F000) | 24'($urandom_range(0, 7) << 2) | 24'($urandom_range(0, 3));
            d = $urandom;
            do_req(w, a, d, ok, rd);
            n_cmp++;
            if (w) begin
                ref_word[widx(a)] = d;
                if (!ok) begin
                    n_err++;
                    $display("FAIL rand_write_ack[%0d]: adr=%h got 0 want 1", i, a);
                end
            end else if (!ok || rd !== ref_word[widx(a)]) begin
                n_err++;
                $display("FAIL rand_read[%0d]: adr=%h got ack=%b rdata=%h want ack=1 rdata=%h",
                         i, a, ok, rd, ref_word[widx(a)]);
            end
        end
    endtask

    task automatic test_reset_mid_read;
        int unsigned a0, f0, n;
        logic [3:0]  got;
        logic [15:0] fr;
        n = 0;
        @(negedge clk);
        while (busy && n < 1000) begin @(negedge clk); n++; end
        a0 = ack_cnt;
        req = 1'b1; we = 1'b0; adr = 24'h000100;
        @(negedge clk);
        req = 1'b0;
        n = 0;
        while (!(!ce_n && rises >= 14 + RD_WAIT + 2) && n < 400) begin @(negedge clk); n++; end
        rst_n = 1'b0;
        #1;
        got = {ce_n, sck, busy, init_done};
        n_cmp++;
        if (got !== 4'b1010) begin
            n_err++;
            $display("FAIL abort_pins: got ce_n,sck,busy,init_done=%b want 1010", got);
        end
        f0 = frames.size();
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!init_done && n < 2000) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        n_cmp++;
        if (ack_cnt != a0) begin
            n_err++;
            $display("FAIL abort_no_ack: got %0d acks want 0", ack_cnt - a0);
        end
        fr = (frames.size() == f0 + 2) ? {frames[f0], frames[f0+1]} : 16'h0000;
        n_cmp++;
        if (fr !== 16'h6699 || init_done !== 1'b1) begin
            n_err++;
            $display("FAIL abort_reinit: got opcodes=%h init_done=%b want 6699 1", fr, init_done);
        end
    endtask

    task automatic test_timing;
        n_cmp++;
        if (lead_bad != 0) begin n_err++; $display("FAIL ce_lead: got %0d bad frames want 0", lead_bad); end
        n_cmp++;
        if (tail_bad != 0) begin n_err++; $display("FAIL ce_tail: got %0d bad frames want 0", tail_bad); end
        n_cmp++;
        if (oe_bad != 0) begin n_err++; $display("FAIL sio_oe_phase: got %0d bad cycles want 0", oe_bad); end
    endtask

    initial begin
        for (int unsigned i = 0; i < MEM_BYTES; i++) mem[i] = 8'h00;
        for (int unsigned i = 0; i < MEM_BYTES / 4; i++) ref_word[i] = 32'h0;
        #1;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_busy_hold();
        test_random();
        test_reset_mid_read();
        test_timing();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
